stream_downsizer: RTL
=====================

# stream_downsizer

Width down-converter for the valid/ready stream fabric. It accepts one wide word of `RATIO` beats per transfer and emits those beats one at a time on a narrow output, with an `out_last` marker on the final beat. It sits directly downstream of `skid_buffer`, which registers the wide input side and absorbs the combinational `out_ready`→`in_ready` path this block creates. Both ports obey the generic AXI-Stream master/slave rules.

## Interface
Parameters:
- `DATA_WIDTH`, default 8: width of one output beat, in bits; must be ≥1.
- `RATIO`, default 4: output beats per input word; must be ≥2.
- `LSB_FIRST`, default 1: 1 emits the least-significant slice first; 0 emits the most-significant slice first.

Ports:
- `clk`  in  1: the single clock; all state updates on its rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `in_data`  in  `DATA_WIDTH*RATIO`: wide input word.
- `in_valid`  in  1: input word valid.
- `in_ready`  out  1: block can accept a word this cycle.
- `out_data`  out  `DATA_WIDTH`: current output beat.
- `out_valid`  out  1: output beat valid.
- `out_ready`  in  1: downstream accepts the beat.
- `out_last`  out  1: current beat is the final slice of its word.

## Operation
- State:
  - `wbuf`: the wide word register.
  - `cnt`: beat index, `$clog2(RATIO)` bits, range 0..RATIO-1.
  - `loaded`: the output-valid flag.
- Output decode:
  - `out_valid = loaded`.
  - `out_last = loaded && cnt == RATIO-1`.
  - `out_data` is slice `cnt` of `wbuf` when `LSB_FIRST`=1, else slice `RATIO-1-cnt`. Slice k is bits `[k*DATA_WIDTH +: DATA_WIDTH]`.
- `in_ready = !reset && (!loaded || (out_ready && cnt == RATIO-1))`.
- Input transfer: `rx = in_valid && in_ready`.
- Output transfer: `tx = out_valid && out_ready`.
- Per clock, in priority order:
  - `reset`: `loaded`←0, `cnt`←0, `wbuf`←0.
  - `rx` (including simultaneous `rx` and final-beat `tx`): `wbuf`←`in_data`, `cnt`←0, `loaded`←1.
  - `tx` with `cnt == RATIO-1`: `loaded`←0, `cnt`←0.
  - `tx` otherwise: `cnt`←`cnt+1`.
  - No transfer: hold all state.
- `cnt` never exceeds RATIO-1. It returns to 0 only on a load or a final-beat transfer; it never wraps past RATIO-1.
- `in_data` is sampled only on `rx`. Its value in any other cycle is ignored.

## Timing
- Reset values, while reset is held and in the first cycle after it deasserts:
  - `out_valid`=0, `out_last`=0, `out_data`=0.
  - `in_ready`=0 while `reset`=1, and 1 in the first cycle after reset deasserts.
- Latency: a word accepted at edge t presents its first beat with `out_valid`=1 from t+1.
- Throughput: with `out_ready` held at 1, one beat per cycle and one word per `RATIO` cycles. A new word is accepted in the same cycle as the last beat, so there are no bubbles.
- `out_valid`, `out_data` and `out_last` are stable while `out_valid && !out_ready`. `out_valid` deasserts only after the final-beat transfer.
- `out_valid` never rises unless a prior `rx` has occurred since reset.
- `in_ready` depends combinationally on `out_ready`. Apart from that path, every output is a pure decode of registers.
- Reset mid-word: the remaining beats are discarded, `out_valid` drops at the next edge, and no partial word is replayed.
- `rx` count × `RATIO` − `tx` count is always in the range 0..RATIO.

## Test plan
- **Basic word, LSB first.** `DATA_WIDTH`=8, `RATIO`=4, `LSB_FIRST`=1, `out_ready`=1; send `in_data`=0xDDCCBBAA once → beats 0xAA, 0xBB, 0xCC, 0xDD on consecutive cycles starting one cycle after acceptance; `out_last`=1 only on 0xDD; `out_valid`=0 afterwards.
- **MSB first.** Same stimulus with `LSB_FIRST`=0 → beats 0xDD, 0xCC, 0xBB, 0xAA; `out_last` on 0xAA.
- **Back-to-back words.** Words 0x44332211 and 0x88776655 offered continuously with `out_ready`=1 → eight beats 0x11…0x88 on eight consecutive cycles; `in_ready`=1 in the cycle of beat 0x44.
- **Backpressure.** During word 0xDDCCBBAA, drop `out_ready` for 3 cycles while 0xBB is presented → 0xBB, `out_valid`=1 and `out_last`=0 are held unchanged; `in_ready`=0 throughout; the sequence resumes with 0xBB accepted exactly once.
- **Reset mid-word.** Assert `reset` for 1 cycle after beat 0xBB transfers → next cycle `out_valid`=0 and `out_data`=0; a following word 0x0D0C0B0A emits 0x0A first.
- **Idle input.** `in_valid`=0 for 20 cycles after reset with `out_ready` toggling → `out_valid` stays 0 and `in_ready` stays 1.

Source files
------------

// File: rtl/stream_downsizer.sv
// Width down-converter: accepts one word of RATIO beats and emits the beats
// one per transfer on a narrow stream, flagging the final beat with out_last.
module stream_downsizer #(
    parameter int DATA_WIDTH = 8,
    parameter int RATIO      = 4,
    parameter int LSB_FIRST  = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [DATA_WIDTH*RATIO-1:0] in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [DATA_WIDTH-1:0]       out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_last
);

    localparam int                CNT_W = $clog2(RATIO);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(RATIO - 1);

    logic [DATA_WIDTH*RATIO-1:0] wbuf;
    logic [CNT_W-1:0]            cnt;
    logic                        loaded;

    logic                        at_last;
    logic                        rx;
    logic                        tx;
    logic [CNT_W-1:0]            idx;

    // Handshake: a transfer happens on a rising edge where valid && ready.
    // Valid never waits on ready; once raised, valid and data hold until
    // the transfer. in_ready is the only output that looks at out_ready.
    assign at_last   = (cnt == LAST);
    assign out_valid = loaded;
    assign out_last  = loaded && at_last;
    assign in_ready  = !reset && (!loaded || (out_ready && at_last));
    assign rx        = in_valid && in_ready;
    assign tx        = out_valid && out_ready;

    // A load takes priority over the final-beat transfer, which is what
    // lets a new word follow the last beat without a bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            loaded <= 1'b0;
            cnt    <= '0;
            wbuf   <= '0;
        end else if (rx) begin
            wbuf   <= in_data;
            cnt    <= '0;
            loaded <= 1'b1;
        end else if (tx && at_last) begin
            loaded <= 1'b0;
            cnt    <= '0;
        end else if (tx) begin
            cnt    <= cnt + 1'b1;
        end
    end

    assign idx = (LSB_FIRST != 0) ? cnt : (LAST - cnt);

    always_comb begin
        out_data = '0;
        for (int k = 0; k < RATIO; k++) begin
            if (idx == CNT_W'(k)) begin
                out_data = wbuf[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

endmodule
